// File: rtl/mram_access_ctrl.sv
// -----------------------------------------------------------------------------
// mram_access_ctrl
//   Two-port round-robin arbiter and SRAM-style timing sequencer for the
//   external 16-bit MRAM. Port 0 is the SPI command path, port 1 the
//   auxiliary/self-test path. Each granted access runs one cycle made of
//   SETUP -> PULSE -> HOLD -> ACK. All pin outputs are registered; the top
//   level builds the DQ tristate from o_mram_dq_out / o_mram_dq_oe.
//
// Ports
//   i_fpga_clk, i_fpga_rst        clock, synchronous active-high reset
//   i_req*/i_we*/i_addr*/
//   i_wdata*/i_be*                per-port request (req held until ack)
//   o_ack0/o_ack1                 one-cycle completion pulse
//   o_rdata                       read data, valid in ack cycle, held after
//   o_busy                        grant .. end of ACK
//   o_mram_*                      MRAM pins (controls active low)
//   i_mram_dq_in                  DQ pin sample
// -----------------------------------------------------------------------------
module mram_access_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic              i_fpga_clk,
  input  logic              i_fpga_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [1:0]        i_be0,
  input  logic [1:0]        i_be1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mram_addr,
  output logic [DATA_W-1:0] o_mram_dq_out,
  output logic              o_mram_dq_oe,
  input  logic [DATA_W-1:0] i_mram_dq_in,
  output logic              o_mram_ce_n,
  output logic              o_mram_oe_n,
  output logic              o_mram_we_n,
  output logic              o_mram_lb_n,
  output logic              o_mram_ub_n
);

  localparam int HALF   = DATA_W / 2;
  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W  = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_ACK} state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              w_req0, w_req1, w_sel;
  logic              w_win;
  logic [DATA_W-1:0] w_rd_mask;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rr_last;
  logic              r_port;
  logic              r_we;
  logic [1:0]        r_be;
  logic              r_ack0, r_ack1, r_busy;
  logic [DATA_W-1:0] r_rdata, r_dq_out;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dq_oe, r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n;

  assign w_req0 = '{we: i_we0, be: i_be0, addr: i_addr0, wdata: i_wdata0};
  assign w_req1 = '{we: i_we1, be: i_be1, addr: i_addr1, wdata: i_wdata1};

  // On a tie the port that was not served last wins.
  always_comb begin
    w_win = 1'b0;
    if (i_req0 && i_req1) w_win = ~r_rr_last;
    else if (i_req1)      w_win = 1'b1;
  end

  assign w_sel = w_win ? w_req1 : w_req0;

  // Disabled byte lanes read back as zero.
  for (genvar b = 0; b < 2; b++) begin : g_lane
    assign w_rd_mask[b*HALF +: HALF] = {HALF{r_be[b]}};
  end

  always_ff @(posedge i_fpga_clk) begin
    if (i_fpga_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rr_last <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 2'b00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
      r_dq_out  <= '0;
      r_addr    <= '0;
      r_dq_oe   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_lb_n    <= 1'b1;
      r_ub_n    <= 1'b1;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_state   <= S_SETUP;
            r_cnt     <= SETUP_LD;
            r_port    <= w_win;
            r_rr_last <= w_win;
            r_we      <= w_sel.we;
            r_be      <= w_sel.be;
            r_busy    <= 1'b1;
            // SETUP pin values are registered here so they appear on grant.
            r_ce_n    <= 1'b0;
            r_addr    <= w_sel.addr;
            r_dq_out  <= w_sel.wdata;
            r_dq_oe   <= w_sel.we;
            r_lb_n    <= ~w_sel.be[0];
            r_ub_n    <= ~w_sel.be[1];
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_PULSE;
            r_cnt   <= PULSE_LD;
            if (r_we) r_we_n <= 1'b0;
            else      r_oe_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            // Sample DQ on the last edge the strobe is still low.
            if (!r_we) r_rdata <= i_mram_dq_in & w_rd_mask;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_ACK;
            r_ce_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_ack0  <= ~r_port;
            r_ack1  <= r_port;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_rdata       = r_rdata;
  assign o_busy        = r_busy;
  assign o_mram_addr   = r_addr;
  assign o_mram_dq_out = r_dq_out;
  assign o_mram_dq_oe  = r_dq_oe;
  assign o_mram_ce_n   = r_ce_n;
  assign o_mram_oe_n   = r_oe_n;
  assign o_mram_we_n   = r_we_n;
  assign o_mram_lb_n   = r_lb_n;
  assign o_mram_ub_n   = r_ub_n;

endmodule
